// File: rtl/serial_cmd_master_pkg.sv
// Shared types and constants for the serial command master.
// Holds the FSM state encoding, processor opcodes, size limits and byte helpers.
package serial_cmd_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TX_WAIT = 3'd1,
      ST_TX_GAP  = 3'd2,
      ST_RX      = 3'd3,
      ST_DONE    = 3'd4,
      ST_TMO     = 3'd5
   } state_t;

   localparam logic [7:0] OP_FW_VERSION  = 8'd0;
   localparam logic [7:0] OP_SET_COINC   = 8'd1;
   localparam logic [7:0] OP_SET_PRESCALE = 8'd7;
   localparam logic [7:0] OP_READ_HIST   = 8'd10;
   localparam logic [7:0] OP_SET_MASK    = 8'd14;
   localparam logic [7:0] OP_READ_CLOCK  = 8'd16;

   localparam int MAX_ARGS = 8;
   localparam int MAX_RESP = 32;

   function automatic logic [3:0] clamp_nargs(input logic [3:0] n);
      return (n > 4'(MAX_ARGS)) ? 4'(MAX_ARGS) : n;
   endfunction

   function automatic logic [5:0] clamp_nresp(input logic [5:0] n);
      return (n > 6'(MAX_RESP)) ? 6'(MAX_RESP) : n;
   endfunction

   // Wire byte idx: 0 is the opcode, idx k>0 is argument byte k-1.
   function automatic logic [7:0] tx_byte(input logic [7:0] opcode,
                                          input logic [63:0] args,
                                          input logic [3:0] idx);
      logic [7:0] b;
      b = opcode;
      for (int k = 0; k < MAX_ARGS; k++) begin
         if (idx == 4'(k + 1)) b = args[8*k +: 8];
      end
      return b;
   endfunction

endpackage

// File: rtl/serial_cmd_master_timer.sv
// Response inactivity timer: counts enabled cycles since the last clear.
// expire_o fires on the cycle the count would reach TIMEOUT_CYCLES-1; clear always wins.
module serial_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 2));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/serial_cmd_master.sv
// Sends opcode + argument bytes to a UART transmitter, then collects a fixed-length reply.
// txStart is combinational on txBusy so the first byte can leave one cycle after accept.
module serial_cmd_master
   import serial_cmd_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [7:0]   cmd_opcode,
   input  logic [3:0]   cmd_nargs,
   input  logic [63:0]  cmd_args,
   input  logic [5:0]   cmd_nresp,
   input  logic         txBusy,
   output logic         txStart,
   output logic [7:0]   txData,
   input  logic         rxReady,
   input  logic [7:0]   rxData,
   output logic         resp_valid,
   output logic         resp_timeout,
   output logic [255:0] resp_data,
   output logic [5:0]   resp_count,
   output logic         busy
);
   state_t         state_q, state_d;
   logic [7:0]     opcode_q;
   logic [63:0]    args_q;
   logic [3:0]     nargs_q;
   logic [5:0]     nresp_q;
   logic [3:0]     tx_idx_q;
   logic [7:0]     tx_data_q;
   logic [255:0]   resp_data_q, resp_data_d;
   logic [5:0]     resp_count_q, resp_count_d;
   logic           accept, tx_fire, rx_fire, rx_last;
   logic           tmr_clr, tmr_en, tmr_expire;

   assign accept  = cmd_valid && (state_q == ST_IDLE);
   assign tx_fire = (state_q == ST_TX_WAIT) && !txBusy;
   assign rx_fire = (state_q == ST_RX) && rxReady;
   assign rx_last = rx_fire && ((resp_count_q + 6'd1) == nresp_q);
   assign tmr_en  = (state_q == ST_RX);
   assign tmr_clr = !tmr_en || rxReady;

   serial_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = ST_TX_WAIT;
         ST_TX_WAIT: if (tx_fire) state_d = ST_TX_GAP;
         ST_TX_GAP: begin
            // tx_idx_q counts bytes already sent; 1+nargs go out in total
            if (tx_idx_q <= nargs_q)  state_d = ST_TX_WAIT;
            else if (nresp_q != 6'd0) state_d = ST_RX;
            else                      state_d = ST_DONE;
         end
         ST_RX: begin
            if (rx_last)         state_d = ST_DONE;
            else if (tmr_expire) state_d = ST_TMO;
         end
         ST_DONE:    state_d = ST_IDLE;
         ST_TMO:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      txStart      = 1'b0;
      resp_valid   = 1'b0;
      resp_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_TX_WAIT: txStart      = !txBusy;
         ST_DONE:    resp_valid   = 1'b1;
         ST_TMO:     resp_timeout = 1'b1;
         default: ;
      endcase
      txData = txStart ? tx_byte(opcode_q, args_q, tx_idx_q) : tx_data_q;
   end

   always_comb begin
      resp_data_d  = resp_data_q;
      resp_count_d = resp_count_q;
      if (accept) begin
         resp_data_d  = '0;
         resp_count_d = '0;
      end else if (rx_fire) begin
         resp_data_d[{resp_count_q[4:0], 3'b000} +: 8] = rxData;
         resp_count_d = resp_count_q + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q     <= '0;
         args_q       <= '0;
         nargs_q      <= '0;
         nresp_q      <= '0;
         tx_idx_q     <= '0;
         tx_data_q    <= '0;
         resp_data_q  <= '0;
         resp_count_q <= '0;
      end else begin
         if (accept) begin
            opcode_q <= cmd_opcode;
            args_q   <= cmd_args;
            nargs_q  <= clamp_nargs(cmd_nargs);
            nresp_q  <= clamp_nresp(cmd_nresp);
            tx_idx_q <= '0;
         end else if (tx_fire) begin
            tx_idx_q  <= tx_idx_q + 4'd1;
            tx_data_q <= txData;
         end
         resp_data_q  <= resp_data_d;
         resp_count_q <= resp_count_d;
      end
   end

   assign resp_data  = resp_data_q;
   assign resp_count = resp_count_q;

endmodule

// File: tb/tb_serial_cmd_master.sv
// Directed bench for serial_cmd_master: table of command transactions plus reset corner cases.
module tb_serial_cmd_master;
   localparam int TMO = 16;

   logic         clk;
   logic         rst_n;
   logic         cmd_valid, cmd_ready;
   logic [7:0]   cmd_opcode;
   logic [3:0]   cmd_nargs;
   logic [63:0]  cmd_args;
   logic [5:0]   cmd_nresp;
   logic         txBusy, txStart;
   logic [7:0]   txData;
   logic         rxReady;
   logic [7:0]   rxData;
   logic         resp_valid, resp_timeout;
   logic [255:0] resp_data;
   logic [5:0]   resp_count;
   logic         busy;

   serial_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_nargs(cmd_nargs), .cmd_args(cmd_args), .cmd_nresp(cmd_nresp),
      .txBusy(txBusy), .txStart(txStart), .txData(txData),
      .rxReady(rxReady), .rxData(rxData),
      .resp_valid(resp_valid), .resp_timeout(resp_timeout),
      .resp_data(resp_data), .resp_count(resp_count), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  op;
      logic [3:0]  nargs;
      logic [63:0] args;
      logic [5:0]  nresp;
      int          nsend;
      int          gap;
      int          busy;
      logic [7:0]  rbase;
      logic        poke;
      logic        exp_tmo;
      logic [5:0]  exp_cnt;
      int          exp_ntx;
      logic [71:0] exp_tx;
      int          exp_dly;
   } vec_t;

   vec_t vecs[9];
   int n_chk = 0;
   int n_fail = 0;

   // Monitor-owned observations, stamped with a negedge cycle counter.
   int cyc, n_valid, n_tmo, n_acc, acc_cyc, rx_last_cyc, tmo_cyc, valid_cyc;
   int busy_cnt, busy_viol, busy_len;
   logic [7:0] tx_log[$];
   int         tx_cyc[$];

   initial begin
      txBusy = 1'b0;
      cyc = 0; n_valid = 0; n_tmo = 0; n_acc = 0; acc_cyc = 0;
      rx_last_cyc = 0; tmo_cyc = 0; valid_cyc = 0; busy_cnt = 0; busy_viol = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (txStart) begin
            tx_log.push_back(txData);
            tx_cyc.push_back(cyc);
            if (txBusy) busy_viol++;
            if (busy_len > 0) busy_cnt = busy_len;
         end
         if (resp_valid)   begin n_valid++; valid_cyc = cyc; end
         if (resp_timeout) begin n_tmo++;   tmo_cyc = cyc;   end
         if (cmd_valid && cmd_ready) begin n_acc++; acc_cyc = cyc; end
         if (rxReady) rx_last_cyc = cyc;
         @(posedge clk);
         #1;
         txBusy = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt--;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int b_tx, b_val, b_tmo, b_acc, n, exp_gap;
      logic done;
      logic [71:0]  got_tx;
      logic [255:0] exp_data;
      b_tx = tx_log.size(); b_val = n_valid; b_tmo = n_tmo; b_acc = n_acc;
      busy_len = v.busy;
      cmd_opcode = v.op; cmd_nargs = v.nargs; cmd_args = v.args; cmd_nresp = v.nresp;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
         if (tx_log.size() - b_tx >= v.exp_ntx) done = 1'b1;
         else begin
            cmd_valid = v.poke && (t >= 10) && (t < 20);
            cmd_opcode = 8'hFF;
            tick();
         end
      end
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_tx_done", id), done, 1);
      if (v.nsend > 0) begin
         tick();
         for (int k = 0; k < v.nsend; k++) begin
            repeat (v.gap) tick();
            rxReady = 1'b1;
            rxData  = v.rbase + 8'(k);
            tick();
            rxReady = 1'b0;
         end
      end
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         if (n_valid + n_tmo > b_val + b_tmo) done = 1'b1;
         else tick();
      end
      chk($sformatf("v%0d_pulse_seen", id), done, 1);
      repeat (3) tick();
      for (int t = 0; t < 200 && txBusy; t++) tick();

      n = tx_log.size() - b_tx;
      chk($sformatf("v%0d_ntx", id), n, v.exp_ntx);
      got_tx = '0;
      for (int k = 0; k < n && k < 9; k++) got_tx[8*k +: 8] = tx_log[b_tx + k];
      chk($sformatf("v%0d_tx_bytes", id), got_tx, v.exp_tx);
      chk($sformatf("v%0d_accepts", id), n_acc - b_acc, 1);
      if (n > 0) chk($sformatf("v%0d_latency", id), tx_cyc[b_tx] - acc_cyc, 1);
      exp_gap = (v.busy + 1 > 2) ? v.busy + 1 : 2;
      for (int k = 1; k < n; k++)
         chk($sformatf("v%0d_tx_spacing%0d", id, k), tx_cyc[b_tx + k] - tx_cyc[b_tx + k - 1], exp_gap);
      chk($sformatf("v%0d_n_valid", id), n_valid - b_val, v.exp_tmo ? 0 : 1);
      chk($sformatf("v%0d_n_timeout", id), n_tmo - b_tmo, v.exp_tmo ? 1 : 0);
      if (v.exp_dly > 0) chk($sformatf("v%0d_tmo_delay", id), tmo_cyc - rx_last_cyc, v.exp_dly);
      if (v.nresp == 0 && n > 0) chk($sformatf("v%0d_done_delay", id), valid_cyc - tx_cyc[b_tx + n - 1], 2);
      chk($sformatf("v%0d_resp_count", id), resp_count, v.exp_cnt);
      exp_data = '0;
      for (int k = 0; k < 32; k++) if (k < int'(v.exp_cnt)) exp_data[8*k +: 8] = v.rbase + 8'(k);
      chk($sformatf("v%0d_resp_data", id), resp_data, exp_data);
      chk($sformatf("v%0d_idle", id), {busy, cmd_ready}, 2'b01);
      chk($sformatf("v%0d_busy_viol", id), busy_viol, 0);
      busy_len = 0;
   endtask

   initial begin
      int b_tx, b_val, b_tmo;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_nargs = '0; cmd_args = '0;
      cmd_nresp = '0; rxReady = 1'b0; rxData = '0; busy_len = 0;

      //          op     na     args                    nr    ns gap busy rbase poke tmo  cnt  ntx exp_tx                      dly
      vecs[0] = '{8'h00, 4'd0,  64'h0,                  6'd1,  1, 0, 0,  8'h07, 1'b0, 1'b0, 6'd1,  1, 72'h00,                   0};
      vecs[1] = '{8'h07, 4'd4,  64'h12345678,           6'd0,  0, 0, 0,  8'h00, 1'b0, 1'b0, 6'd0,  5, 72'h12_34_56_78_07,       0};
      vecs[2] = '{8'h0A, 4'd0,  64'h0,                  6'd32, 32, 3, 0, 8'h00, 1'b0, 1'b0, 6'd32, 1, 72'h0A,                   0};
      vecs[3] = '{8'h01, 4'd1,  64'h03,                 6'd8,  3, 0, 0,  8'hA0, 1'b0, 1'b1, 6'd3,  2, 72'h03_01,                16};
      vecs[4] = '{8'h0E, 4'd15, 64'h8877665544332211,   6'd40, 33, 0, 0, 8'h40, 1'b0, 1'b0, 6'd32, 9, 72'h88_77_66_55_44_33_22_11_0E, 0};
      vecs[5] = '{8'h10, 4'd1,  64'h5A,                 6'd4,  4, 1, 2,  8'hC0, 1'b0, 1'b0, 6'd4,  2, 72'h5A_10,                0};
      vecs[6] = '{8'h01, 4'd0,  64'h0,                  6'd2,  2, 14, 0, 8'h30, 1'b0, 1'b0, 6'd2,  1, 72'h01,                   0};
      vecs[7] = '{8'h01, 4'd0,  64'h0,                  6'd2,  2, 15, 0, 8'h30, 1'b0, 1'b1, 6'd0,  1, 72'h01,                   0};
      vecs[8] = '{8'h07, 4'd2,  64'hBEEF,               6'd0,  0, 0, 50, 8'h00, 1'b1, 1'b0, 6'd0,  3, 72'hBE_EF_07,             0};

      repeat (3) tick();
      chk("rst_outputs", {busy, txStart, txData, resp_valid, resp_timeout, resp_count}, '0);
      chk("rst_resp_data", resp_data, '0);
      rst_n = 1'b1;
      tick();
      chk("rst_release_ready", {cmd_ready, busy}, 2'b10);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset in the middle of a READ_CLOCK reply, then a normal command.
      b_tx = tx_log.size(); b_val = n_valid; b_tmo = n_tmo;
      cmd_opcode = 8'h10; cmd_nargs = 4'd0; cmd_args = '0; cmd_nresp = 6'd4;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int t = 0; t < 50 && tx_log.size() == b_tx; t++) tick();
      tick();
      rxReady = 1'b1; rxData = 8'h11; tick();
      rxData = 8'h22; tick();
      rxReady = 1'b0;
      chk("mid_partial_count", resp_count, 6'd2);
      chk("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs", {busy, txStart, txData, resp_valid, resp_timeout, resp_count}, '0);
      chk("mid_rst_resp_data", resp_data, '0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("mid_no_pulse", (n_valid - b_val) + (n_tmo - b_tmo), 0);
      chk("mid_no_extra_tx", tx_log.size() - b_tx, 1);
      chk("mid_ready", cmd_ready, 1'b1);
      run_vec(vecs[0], 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
